// File: rtl/fetch_seq_ctrl.sv
// ============================================================================
// fetch_seq_ctrl : fetch-stage sequencer (stall/branch/bubble/halt control).
// Optional perf counters when FETCH_PERF_COUNT_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module fetch_seq_ctrl #(
    parameter int LOAD_LAT     = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        Init,
    input  logic        Start,
    input  logic        BranchReq,
    input  logic [2:0]  BranchTarget,
    input  logic        LoadReq,
    input  logic        HaltReq,
    output logic        Branch,
    output logic [2:0]  Target,
    output logic        Stall,
    output logic        Bubble,
    output logic        Halted
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [15:0] CycleCount,
    output logic [15:0] StallCount
`endif
);

    generate
        if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_load_lat
            $error("fetch_seq_ctrl: LOAD_LAT out of range 1..15");
        end
        if (FLUSH_CYCLES < 0 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
            $error("fetch_seq_ctrl: FLUSH_CYCLES out of range 0..15");
        end
    endgenerate

    localparam logic [3:0] c_load_init  = 4'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
    localparam logic [3:0] c_flush_init = 4'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_LOAD_WAIT = 3'd2,
        S_FLUSH     = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       bubble_q;
    logic       halted_q;

    always_ff @(posedge CLK) begin
        if (Init) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            bubble_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (HaltReq) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (BranchReq) begin
                        if (FLUSH_CYCLES > 0) begin
                            state_q  <= S_FLUSH;
                            cnt_q    <= c_flush_init;
                            bubble_q <= 1'b1;
                        end
                    end else if (LoadReq) begin
                        if (LOAD_LAT > 1) begin
                            state_q <= S_LOAD_WAIT;
                            cnt_q   <= c_load_init;
                        end
                    end
                end
                S_LOAD_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= S_RUN;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                S_FLUSH: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= S_RUN;
                        bubble_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= S_IDLE;
                    bubble_q <= 1'b0;
                end
            endcase
        end
    end

    // Fetch controls are combinational so the PC register reacts on this edge.
    always_comb begin
        Branch = 1'b0;
        Target = 3'd0;
        Stall  = 1'b0;
        if (!Init) begin
            case (state_q)
                S_IDLE:      Stall = ~Start;
                S_RUN: begin
                    if (HaltReq) begin
                        Stall = 1'b1;
                    end else if (BranchReq) begin
                        Branch = 1'b1;
                        Target = BranchTarget;
                    end else if (LoadReq) begin
                        Stall = 1'b1;
                    end
                end
                S_LOAD_WAIT: Stall = 1'b1;
                S_FLUSH:     Stall = 1'b0;
                S_HALT:      Stall = 1'b1;
                default:     Stall = 1'b1;
            endcase
        end
    end

    assign Bubble = bubble_q;
    assign Halted = halted_q;

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] cycle_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge CLK) begin
        if (Init) begin
            cycle_cnt_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if ((state_q == S_RUN || state_q == S_LOAD_WAIT || state_q == S_FLUSH)
                && cycle_cnt_q != 16'hFFFF) begin
                cycle_cnt_q <= cycle_cnt_q + 16'd1;
            end
            if (Stall && (state_q == S_RUN || state_q == S_LOAD_WAIT)
                && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign CycleCount = cycle_cnt_q;
    assign StallCount = stall_cnt_q;
`endif

endmodule

`default_nettype wire
